keypad_scan: RTL

Scans the 4×4 calculator keypad matrix by walking one active-low column drive across `V` and sampling the row returns on `H`. It assembles one 16-bit frame per full column sweep and debounces whole frames. It presents the stable key map as a level-held 16-bit vector to the downstream key encoder. It is the stage directly upstream of the encoder inside the input subsystem.

---
 rtl/keypad_scan_pkg.sv | 29 ++
 rtl/keypad_scan_frame_debounce.sv | 96 +++++++++
 rtl/keypad_scan.sv | 102 ++++++++++
 3 files changed

// File: rtl/keypad_scan_pkg.sv
// keypad_scan_pkg
// Shared definitions for the 4x4 keypad input path. Used by the scanner and
// by the downstream key encoder.
//   KP_ROWS / KP_COLS : matrix geometry
//   KP_KEYS           : key map width (one bit per key)
//   key_map_t         : active-high key map, bit index = KP_ROWS*col + row
//   kp_key_index()    : key-index rule
//   kp_multi_hot()    : true when more than one key bit is set
package keypad_scan_pkg;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;
  localparam int KP_KEYS = KP_ROWS * KP_COLS;

  typedef logic [KP_KEYS-1:0] key_map_t;
  typedef logic [1:0]         col_idx_t;
  typedef logic [KP_ROWS-1:0] row_vec_t;

  // Bit position of the key at (col, row) inside a key map.
  function automatic int kp_key_index(input int col, input int row);
    return (KP_ROWS * col) + row;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic kp_multi_hot(input key_map_t m);
    return ((m & (m - 16'd1)) != 16'd0);
  endfunction

endpackage

// File: rtl/keypad_scan_frame_debounce.sv
// keypad_frame_debounce
// Whole-frame debouncer. Publishes a frame on key_o once DEBOUNCE consecutive
// identical frames have been seen, pulsing key_chg_o for one cycle whenever
// the published value actually changes.
// Optional build macro: KEYPAD_GHOST_REJECT_EN -- frames with more than one key
// set are discarded (counter cleared, prev/key untouched, no pulse).
// Ports:
//   clk_i       : clock, rising edge
//   rst_ni      : asynchronous active-low reset
//   frame_i     : assembled key frame (valid when frame_end_i is high)
//   frame_end_i : one-cycle strobe marking a completed sweep
//   key_o       : debounced key map (registered)
//   key_chg_o   : one-cycle pulse following an update of key_o (registered)
module keypad_frame_debounce
  import keypad_scan_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  key_map_t frame_i,
  input  logic     frame_end_i,
  output key_map_t key_o,
  output logic     key_chg_o
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_MAX  = cnt_t'(DEBOUNCE);
  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam cnt_t CNT_ZERO = cnt_t'(0);

  key_map_t prev_q, prev_d;
  key_map_t key_q,  key_d;
  cnt_t     cnt_q,  cnt_d;
  logic     chg_q,  chg_d;
  logic     ghost_s;

`ifdef KEYPAD_GHOST_REJECT_EN
  assign ghost_s = kp_multi_hot(frame_i);
`else
  assign ghost_s = 1'b0;
`endif

  // Next-state evaluation, only acting on the frame-end strobe.
  always_comb begin
    prev_d = prev_q;
    key_d  = key_q;
    cnt_d  = cnt_q;
    chg_d  = 1'b0;
    if (frame_end_i) begin
      if (ghost_s) begin
        cnt_d = CNT_ZERO;
      end else begin
        prev_d = frame_i;
        if (frame_i == prev_q) begin
          // Saturate so a long stable press keeps re-qualifying.
          if (cnt_q >= CNT_MAX) begin
            cnt_d = CNT_MAX;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = CNT_ONE;
        end
        if ((cnt_d == CNT_MAX) && (frame_i != key_q)) begin
          key_d = frame_i;
          chg_d = 1'b1;
        end else begin
          chg_d = 1'b0;
        end
      end
    end else begin
      chg_d = 1'b0;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 16'h0000;
      key_q  <= 16'h0000;
      cnt_q  <= CNT_ZERO;
      chg_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      key_q  <= key_d;
      cnt_q  <= cnt_d;
      chg_q  <= chg_d;
    end
  end

  assign key_o     = key_q;
  assign key_chg_o = chg_q;

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan
// Scans a 4x4 keypad by walking one active-low column drive across V and
// sampling the active-low row returns on H at the last cycle of each column
// slot. One frame is assembled per sweep and debounced as a whole.
// Optional build macro: KEYPAD_GHOST_REJECT_EN (see keypad_frame_debounce).
// Parameters:
//   SCAN_DIV : clock cycles per column slot (>= 2)
//   DEBOUNCE : identical frames required before key updates (>= 2)
// Ports:
//   Clock   : clock, rising edge
//   Reset   : asynchronous active-low reset
//   H       : row returns, active-low
//   V       : column drive, active-low, exactly one bit low (registered)
//   key     : debounced key map, bit = 4*col + row (registered)
//   key_chg : one-cycle pulse when key changes value (registered)
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [KP_ROWS-1:0]  H,
  output logic [KP_COLS-1:0]  V,
  output logic [KP_KEYS-1:0]  key,
  output logic                key_chg
);

  localparam int DIV_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int STORED_W = KP_KEYS - KP_ROWS;
  typedef logic [DIV_W-1:0] div_t;
  localparam div_t DIV_LAST = div_t'(SCAN_DIV - 1);
  localparam div_t DIV_ONE  = div_t'(1);
  localparam div_t DIV_ZERO = div_t'(0);

  div_t                  div_q, div_d;
  col_idx_t              col_q, col_d;
  logic [KP_COLS-1:0]    v_q, v_d;
  logic [STORED_W-1:0]   frame_q, frame_d;
  row_vec_t              row_s;
  logic                  slot_end_s;
  logic                  frame_end_s;
  key_map_t              frame_s;

  assign row_s       = ~H;
  assign slot_end_s  = (div_q == DIV_LAST);
  assign frame_end_s = slot_end_s && (col_q == 2'd3);
  // Column 3 is never stored: it joins the frame live on the frame-end edge.
  assign frame_s     = {row_s, frame_q};

  // Slot counter, column walk, next drive pattern and row capture.
  always_comb begin
    div_d   = div_q;
    col_d   = col_q;
    v_d     = v_q;
    frame_d = frame_q;
    if (slot_end_s) begin
      div_d = DIV_ZERO;
      col_d = col_q + 2'd1;
      // Drive is computed from the next column so V and col move together.
      v_d   = ~(4'b0001 << col_d);
      case (col_q)
        2'd0:    frame_d[kp_key_index(0, 0) +: KP_ROWS] = row_s;
        2'd1:    frame_d[kp_key_index(1, 0) +: KP_ROWS] = row_s;
        2'd2:    frame_d[kp_key_index(2, 0) +: KP_ROWS] = row_s;
        default: frame_d = frame_q;
      endcase
    end else begin
      div_d = div_q + DIV_ONE;
    end
  end

  // Scan state registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      div_q   <= DIV_ZERO;
      col_q   <= 2'd0;
      v_q     <= 4'b1110;
      frame_q <= 12'h000;
    end else begin
      div_q   <= div_d;
      col_q   <= col_d;
      v_q     <= v_d;
      frame_q <= frame_d;
    end
  end

  keypad_frame_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk_i       (Clock),
    .rst_ni      (Reset),
    .frame_i     (frame_s),
    .frame_end_i (frame_end_s),
    .key_o       (key),
    .key_chg_o   (key_chg)
  );

  assign V = v_q;

endmodule
